video_mode_ctrl: RTL

//  Runtime-programmable video timing controller feeding the dvid encoder. Holds the active

---
 rtl/video_mode_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/video_mode_ctrl.sv
// Video timing controller: live/shadow mode registers, frame-boundary commit,
// registered hsync/vsync/blank/x/y/frame_start outputs.
module video_mode_ctrl #(
    parameter int unsigned CW       = 11,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic [1:0]  POL      = 2'b00
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    input  logic          cfg_commit,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start
);

    typedef enum logic [1:0] {StStop, StRun, StSwitch} state_e;

    function automatic logic [CW-1:0] dflt(input int unsigned i);
        case (i)
            0:       return CW'(H_ACTIVE);
            1:       return CW'(H_FP);
            2:       return CW'(H_SYNC);
            3:       return CW'(H_BP);
            4:       return CW'(V_ACTIVE);
            5:       return CW'(V_FP);
            6:       return CW'(V_SYNC);
            default: return CW'(V_BP);
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CW-1:0] live_q [8];
    logic [CW-1:0] live_d [8];
    logic [CW-1:0] shad_q [8];
    logic [CW-1:0] shad_d [8];
    logic [1:0]    lpol_q, lpol_d, spol_q, spol_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
    logic          fs_q, fs_d, pend_q, pend_d, err_q, err_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;

    logic [CW:0]   ht, vt, hs_lo, hs_hi, vs_lo, vs_hi;
    logic [CW+1:0] sh_ht, sh_vt;  // two extra bits so the sum itself cannot wrap
    logic          sh_zero, sh_valid, h_end, v_end, frame_end, count_en, load;
    logic          hs_act, vs_act, act;

    // Totals, sync windows and commit validation.
    always_comb begin
        ht    = {1'b0, live_q[0]} + {1'b0, live_q[1]} + {1'b0, live_q[2]} + {1'b0, live_q[3]};
        vt    = {1'b0, live_q[4]} + {1'b0, live_q[5]} + {1'b0, live_q[6]} + {1'b0, live_q[7]};
        hs_lo = {1'b0, live_q[0]} + {1'b0, live_q[1]};
        hs_hi = hs_lo + {1'b0, live_q[2]};
        vs_lo = {1'b0, live_q[4]} + {1'b0, live_q[5]};
        vs_hi = vs_lo + {1'b0, live_q[6]};
        sh_ht = {2'b00, shad_q[0]} + {2'b00, shad_q[1]} + {2'b00, shad_q[2]} + {2'b00, shad_q[3]};
        sh_vt = {2'b00, shad_q[4]} + {2'b00, shad_q[5]} + {2'b00, shad_q[6]} + {2'b00, shad_q[7]};
        sh_zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (shad_q[i] == '0) sh_zero = 1'b1;
        end
        sh_valid  = !sh_zero && (sh_ht[CW+1:CW] == 2'b00) && (sh_vt[CW+1:CW] == 2'b00);
        h_end     = ({1'b0, h_cnt_q} == ht - (CW+1)'(1));
        v_end     = ({1'b0, v_cnt_q} == vt - (CW+1)'(1));
        frame_end = h_end && v_end;
    end

    // Next state: FSM, counters, live/shadow updates.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        load    = 1'b0;
        if (h_end) begin
            h_cnt_d = '0;
            v_cnt_d = v_end ? '0 : v_cnt_q + CW'(1);
        end else begin
            h_cnt_d = h_cnt_q + CW'(1);
        end
        unique case (state_q)
            StStop: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                load    = cfg_commit && sh_valid;
                if (run) state_d = StRun;
            end
            StRun: begin
                if (!run) begin
                    state_d = StStop;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                end else if (cfg_commit && sh_valid) begin
                    state_d = StSwitch;
                end
            end
            StSwitch: begin
                if (!run) begin
                    state_d = StStop;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                    load    = 1'b1;
                end else if (frame_end) begin
                    state_d = StRun;
                    load    = 1'b1;
                end
            end
            default: state_d = StStop;
        endcase
        live_d = load ? shad_q : live_q;
        lpol_d = load ? spol_q : lpol_q;
        // Shadow writes land after any copy on the same edge.
        shad_d = shad_q;
        spol_d = spol_q;
        if (cfg_we) begin
            if (cfg_addr < 4'd8)       shad_d[cfg_addr[2:0]] = cfg_wdata;
            else if (cfg_addr == 4'd8) spol_d = cfg_wdata[1:0];
        end
        err_d  = cfg_commit && (state_q != StSwitch) && !sh_valid;
        pend_d = (state_d == StSwitch);
    end

    // Registered pixel outputs describing this cycle's counters.
    always_comb begin
        count_en = (state_q != StStop) && run;
        hs_act   = ({1'b0, h_cnt_q} >= hs_lo) && ({1'b0, h_cnt_q} < hs_hi);
        vs_act   = ({1'b0, v_cnt_q} >= vs_lo) && ({1'b0, v_cnt_q} < vs_hi);
        act      = (h_cnt_q < live_q[0]) && (v_cnt_q < live_q[4]);
        hsync_d  = ~lpol_q[0];
        vsync_d  = ~lpol_q[1];
        blank_d  = 1'b1;
        x_d      = '0;
        y_d      = '0;
        fs_d     = 1'b0;
        if (count_en) begin
            hsync_d = ~(hs_act ^ lpol_q[0]);
            vsync_d = ~(vs_act ^ lpol_q[1]);
            blank_d = !act;
            x_d     = act ? h_cnt_q : '0;
            y_d     = act ? v_cnt_q : '0;
            fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StStop;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            for (int i = 0; i < 8; i++) begin
                live_q[i] <= dflt(i);
                shad_q[i] <= dflt(i);
            end
            lpol_q  <= POL;
            spol_q  <= POL;
            hsync_q <= ~POL[0];
            vsync_q <= ~POL[1];
            blank_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            live_q  <= live_d;
            shad_q  <= shad_d;
            lpol_q  <= lpol_d;
            spol_q  <= spol_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign cfg_pending = pend_q;
    assign cfg_err     = err_q;

endmodule
